// File: rtl/bus_master_if.sv
// +---------------------------------------------------------------------------+
// | bus_master_if : single-word request path to 8 slaves with bus timeout     |
// | Revision      : 1.0                                                       |
// +---------------------------------------------------------------------------+
`default_nettype none

module bus_master_if #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        req_rw,
  input  logic [29:0] req_addr,
  input  logic [31:0] req_wr_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rd_data,
  output logic [29:0] s_addr,
  output logic        s_as_,
  output logic        s_rw,
  output logic [31:0] s_wr_data,
  output logic        s0_cs_,
  output logic        s1_cs_,
  output logic        s2_cs_,
  output logic        s3_cs_,
  output logic        s4_cs_,
  output logic        s5_cs_,
  output logic        s6_cs_,
  output logic        s7_cs_,
  input  logic [31:0] m_rd_data,
  input  logic        m_rdy_
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [31:0]    rd_data_q, rd_data_d;
  logic [29:0]    addr_q, addr_d;
  logic           as_q, as_d;
  logic           rw_q, rw_d;
  logic [31:0]    wr_data_q, wr_data_d;
  logic [7:0]     cs_q, cs_d;
  logic [TW-1:0]  timer_q, timer_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
      addr_q    <= '0;
      as_q      <= 1'b1;
      rw_q      <= 1'b1;
      wr_data_q <= '0;
      cs_q      <= 8'hFF;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
      addr_q    <= addr_d;
      as_q      <= as_d;
      rw_q      <= rw_d;
      wr_data_q <= wr_data_d;
      cs_q      <= cs_d;
      timer_q   <= timer_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rd_data_d = rd_data_q;
    addr_d    = addr_q;
    as_d      = as_q;
    rw_d      = rw_q;
    wr_data_d = wr_data_q;
    cs_d      = cs_q;
    timer_d   = timer_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d    = req_addr;
          rw_d      = req_rw;
          wr_data_d = req_wr_data;
          cs_d      = ~(8'h01 << req_addr[29:27]);
          as_d      = 1'b0;
          busy_d    = 1'b1;
          timer_d   = '0;
          state_d   = ACCESS;
        end
      end
      ACCESS, WAIT: begin
        as_d = 1'b1;
        // Ready wins over timeout when both land on the same edge.
        if (!m_rdy_) begin
          if (rw_q) rd_data_d = m_rd_data;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cs_d    = 8'hFF;
          state_d = IDLE;
        end else if (timer_q == TMAX) begin
          done_d    = 1'b1;
          err_d     = 1'b1;
          busy_d    = 1'b0;
          rd_data_d = '0;
          cs_d      = 8'hFF;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rd_data   = rd_data_q;
  assign s_addr    = addr_q;
  assign s_as_     = as_q;
  assign s_rw      = rw_q;
  assign s_wr_data = wr_data_q;
  assign s0_cs_    = cs_q[0];
  assign s1_cs_    = cs_q[1];
  assign s2_cs_    = cs_q[2];
  assign s3_cs_    = cs_q[3];
  assign s4_cs_    = cs_q[4];
  assign s5_cs_    = cs_q[5];
  assign s6_cs_    = cs_q[6];
  assign s7_cs_    = cs_q[7];

endmodule

`default_nettype wire
